// File: rtl/mips_regfile_pkg.sv
// mips_regfile_pkg -- shared defaults and index type for the multi-port
// MIPS register file with per-register pending (scoreboard) bits.
package mips_regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_N_READ = 2;

  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/mips_regfile_mp_if.sv
// mips_regfile_mp_if -- bundles the read, write and mark signals of the
// register file. The pipeline side uses the master modport, the register
// file itself uses the slave modport.
interface mips_regfile_mp_if
  import mips_regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int N_READ = DEF_N_READ
);

  logic [N_READ*ADDR_W-1:0] read_reg;
  logic [N_READ*DATA_W-1:0] read_data;
  logic [N_READ-1:0]        read_pending;

  logic                     wr_en_a;
  logic [ADDR_W-1:0]        wr_reg_a;
  logic [DATA_W-1:0]        wr_data_a;

  logic                     wr_en_b;
  logic [ADDR_W-1:0]        wr_reg_b;
  logic [DATA_W-1:0]        wr_data_b;

  logic                     mark_en;
  logic [ADDR_W-1:0]        mark_reg;

  modport master (
    output read_reg,
    output wr_en_a, wr_reg_a, wr_data_a,
    output wr_en_b, wr_reg_b, wr_data_b,
    output mark_en, mark_reg,
    input  read_data, read_pending
  );

  modport slave (
    input  read_reg,
    input  wr_en_a, wr_reg_a, wr_data_a,
    input  wr_en_b, wr_reg_b, wr_data_b,
    input  mark_en, mark_reg,
    output read_data, read_pending
  );

endinterface

// File: rtl/mips_regfile_read_port.sv
// mips_regfile_read_port -- one combinational read port: index lookup,
// register-0 / reset zero-forcing and pending lookup.
// Optional macro MIPS_REGFILE_BYPASS_EN: forward same-cycle write data
// (port B over port A) and hide a pending bit that this cycle's write clears.
module mips_regfile_read_port
  import mips_regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  localparam int DEPTH = 2**ADDR_W
) (
  input  logic                          i_reset,
  input  logic [ADDR_W-1:0]             i_rd_reg,
  input  logic [DEPTH-1:0][DATA_W-1:0]  i_regs,
  input  logic [DEPTH-1:0]              i_pend,
  input  logic                          i_wr_en_a,
  input  logic [ADDR_W-1:0]             i_wr_reg_a,
  input  logic [DATA_W-1:0]             i_wr_data_a,
  input  logic                          i_wr_en_b,
  input  logic [ADDR_W-1:0]             i_wr_reg_b,
  input  logic [DATA_W-1:0]             i_wr_data_b,
  input  logic                          i_mark_en,
  input  logic [ADDR_W-1:0]             i_mark_reg,
  output logic [DATA_W-1:0]             o_rd_data,
  output logic                          o_rd_pending
);

  logic [DATA_W-1:0] w_stored;
  logic              w_pend_raw;
  logic [DATA_W-1:0] w_data;
  logic              w_pend;
  logic              w_is_zero;

  assign w_stored   = i_regs[i_rd_reg];
  assign w_pend_raw = i_pend[i_rd_reg];
  assign w_is_zero  = (i_rd_reg == '0);

`ifdef MIPS_REGFILE_BYPASS_EN
  logic w_hit_a;
  logic w_hit_b;
  logic w_hit_mark;

  assign w_hit_a    = i_wr_en_a && (i_wr_reg_a == i_rd_reg);
  assign w_hit_b    = i_wr_en_b && (i_wr_reg_b == i_rd_reg);
  assign w_hit_mark = i_mark_en && (i_mark_reg == i_rd_reg);

  // Forward in-flight write data; B is the load result and takes priority.
  // A completing write hides the pending bit unless a new producer claims it.
  always_comb begin
    w_data = w_stored;
    w_pend = w_pend_raw;
    if (w_hit_a) w_data = i_wr_data_a;
    if (w_hit_b) w_data = i_wr_data_b;
    if ((w_hit_a || w_hit_b) && !w_hit_mark) w_pend = 1'b0;
  end
`else
  // Without forwarding the write and mark inputs only matter at the edge.
  logic w_unused;
  assign w_unused = ^{i_wr_en_a, i_wr_reg_a, i_wr_data_a,
                      i_wr_en_b, i_wr_reg_b, i_wr_data_b,
                      i_mark_en, i_mark_reg};

  assign w_data = w_stored;
  assign w_pend = w_pend_raw;
`endif

  // $zero and an active reset both read as an idle zero register.
  assign o_rd_data    = (i_reset || w_is_zero) ? '0 : w_data;
  assign o_rd_pending = (i_reset || w_is_zero) ? 1'b0 : w_pend;

endmodule

// File: rtl/mips_regfile_mp.sv
// mips_regfile_mp -- MIPS register file with N_READ combinational read
// ports, two write ports (A = ALU, B = load, B wins on collision) and a
// pending bit per register tracking outstanding producers.
// Optional macro MIPS_REGFILE_BYPASS_EN enables same-cycle write forwarding
// in every read port.
module mips_regfile_mp
  import mips_regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int N_READ = DEF_N_READ
) (
  input  logic               clock,
  input  logic               reset,
  mips_regfile_mp_if.slave   bus
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] r_regs;
  logic [DEPTH-1:0]             r_pend;
  logic [DEPTH-1:0]             w_pend_next;
  logic                         w_wr_a_ok;
  logic                         w_wr_b_ok;
  logic                         w_mark_ok;

  // Writes and marks to $zero are dropped here so index 0 never holds state.
  assign w_wr_a_ok = bus.wr_en_a && (bus.wr_reg_a != '0);
  assign w_wr_b_ok = bus.wr_en_b && (bus.wr_reg_b != '0);
  assign w_mark_ok = bus.mark_en && (bus.mark_reg != '0);

  // Register storage; port B is applied last so it wins a same-index collision.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_regs <= '0;
    end else begin
      if (w_wr_a_ok) r_regs[bus.wr_reg_a] <= bus.wr_data_a;
      if (w_wr_b_ok) r_regs[bus.wr_reg_b] <= bus.wr_data_b;
    end
  end

  // Pending update: completing writes clear, a new producer mark sets last.
  always_comb begin
    w_pend_next = r_pend;
    if (w_wr_a_ok) w_pend_next[bus.wr_reg_a] = 1'b0;
    if (w_wr_b_ok) w_pend_next[bus.wr_reg_b] = 1'b0;
    if (w_mark_ok) w_pend_next[bus.mark_reg] = 1'b1;
  end

  // Pending bit register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_next;
    end
  end

  for (genvar k = 0; k < N_READ; k++) begin : g_rd
    mips_regfile_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_rd (
      .i_reset      (reset),
      .i_rd_reg     (bus.read_reg[k*ADDR_W +: ADDR_W]),
      .i_regs       (r_regs),
      .i_pend       (r_pend),
      .i_wr_en_a    (bus.wr_en_a),
      .i_wr_reg_a   (bus.wr_reg_a),
      .i_wr_data_a  (bus.wr_data_a),
      .i_wr_en_b    (bus.wr_en_b),
      .i_wr_reg_b   (bus.wr_reg_b),
      .i_wr_data_b  (bus.wr_data_b),
      .i_mark_en    (bus.mark_en),
      .i_mark_reg   (bus.mark_reg),
      .o_rd_data    (bus.read_data[k*DATA_W +: DATA_W]),
      .o_rd_pending (bus.read_pending[k])
    );
  end

endmodule

// File: doc/mips_regfile_mp.md
MIPS_REGFILE_MP -- requirements
Module: mips_regfile_mp

Interface
REQ-001 Parameter DATA_W, 32, register width in bits, SHALL be >= 8.
REQ-002 Parameter ADDR_W, 5, register index width; depth SHALL be 2**ADDR_W.
REQ-003 Parameter N_READ, 2, number of independent read ports, range 1..4.
REQ-004 clock  input  1  single clock, all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 read_reg  input  N_READ*ADDR_W  packed read indices, port k at bits [k*ADDR_W +: ADDR_W].
REQ-007 read_data  output  N_READ*DATA_W  packed read data, port k at bits [k*DATA_W +: DATA_W].
REQ-008 read_pending  output  N_READ  port k indexed register has an outstanding producer.
REQ-009 wr_en_a, wr_reg_a, wr_data_a  input  1/ADDR_W/DATA_W  write port A (ALU result).
REQ-010 wr_en_b, wr_reg_b, wr_data_b  input  1/ADDR_W/DATA_W  write port B (load result).
REQ-011 mark_en, mark_reg  input  1/ADDR_W  declares a new in-flight producer for mark_reg.

Function
REQ-012 Reads SHALL be combinational from current state; zero-cycle latency.
REQ-013 Register 0 SHALL always read 0 and never be pending; writes and marks to index 0 SHALL be ignored.
REQ-014 Enabled write SHALL update the target register on the next rising clock edge.
REQ-015 Both ports writing the same nonzero index in one cycle: port B data SHALL be stored.
REQ-016 Pending bit per register: mark_en sets it at the edge; an enabled write (A or B) to that index clears it.
REQ-017 Mark and write to the same index in one cycle: pending SHALL end set (new producer wins); data SHALL still be written.
REQ-018 Marking an already-pending index SHALL leave it pending; no counting.
REQ-019 read_pending[k] SHALL reflect the registered pending bit; under bypass (REQ-024) a same-cycle write to that index SHALL force it 0 unless a same-cycle mark targets it.
REQ-020 Write and mark on distinct indices SHALL act independently in the same cycle.

Reset
REQ-021 reset asserted SHALL immediately clear all registers to 0 and all pending bits to 0, independent of clock.
REQ-022 While reset is high, writes and marks SHALL be ignored; read_data SHALL be 0, read_pending 0.
REQ-023 Reset asserted mid-operation SHALL discard any write presented in that cycle.

Configuration
REQ-024 Macro MIPS_REGFILE_BYPASS_EN defined: a read whose index matches an enabled same-cycle write SHALL return the write data (B over A); index 0 still reads 0.
REQ-025 Macro undefined: reads SHALL return pre-edge stored value; a same-cycle write is visible only from the next cycle; read_pending is the raw registered bit.

Structure
REQ-026 Package mips_regfile_pkg SHALL hold default DATA_W/ADDR_W/N_READ constants and the register-index typedef.
REQ-027 One sub-module mips_regfile_read_port SHALL implement a single read port (index lookup, zero-force, bypass, pending); instantiated N_READ times via generate.
REQ-028 No memory-file initialisation; contents SHALL originate only from reset and writes.

Verification
REQ-029 Reset pulse mid-cycle, then read all 32 indices -> every read_data 0, read_pending 0, no clock edge required.
REQ-030 wr_en_a=1 reg 5 0x0000_1234 and wr_en_b=1 reg 5 0xDEAD_BEEF same cycle -> next cycle reg 5 reads 0xDEAD_BEEF.
REQ-031 Write 0xFFFF_FFFF to reg 0 and mark reg 0 -> reg 0 reads 0, read_pending 0 on all ports.
REQ-032 mark reg 8; two cycles later wr_en_b reg 8 0x55 with mark reg 8 in the same cycle -> reg 8 = 0x55, read_pending still 1; next write to 8 without mark -> pending 0.
REQ-033 With MIPS_REGFILE_BYPASS_EN: read reg 9 while wr_en_a reg 9 0xABCD -> read_data 0xABCD same cycle; without macro -> old value, 0xABCD next cycle.
REQ-034 N_READ=4, DATA_W=64: distinct writes to regs 1..4, all ports read 1..4 -> each port returns its own 64-bit value.
